inf_rcv_nec: RTL and testbench

Parametrised NEC infrared frame receiver, the next generation of the team's IR receive block. It filters the demodulated IR input and measures pulse and space widths against windows derived from the clock frequency and a tolerance parameter. It decodes the full 32-bit NEC frame, checks it, and reports address, command, repeat codes and key-hold status to the key-handling and display logic. It also reports framing and checksum errors.

---
 rtl/inf_pkg.sv | 32 +++
 rtl/inf_rcv_nec_deglitch.sv | 54 +++++
 rtl/inf_rcv_nec.sv | 242 ++++++++++++++++++++++++
 tb/tb_inf_rcv_nec.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/inf_pkg.sv
// Shared definitions for the NEC infrared receiver.
//   inf_state_e  : receiver state machine encoding
//   *Us          : nominal NEC pulse/space widths in microseconds
//   win_cycles() : width in microseconds scaled to clock cycles and a percentage
package inf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StSpace,
    StBitMark,
    StBitSpace,
    StStop,
    StRptMark
  } inf_state_e;

  localparam int unsigned LeadMarkUs  = 9000;
  localparam int unsigned DataSpaceUs = 4500;
  localparam int unsigned RptSpaceUs  = 2250;
  localparam int unsigned BitMarkUs   = 560;
  localparam int unsigned ZeroSpaceUs = 560;
  localparam int unsigned OneSpaceUs  = 1690;

  // Nominal cycles are truncated first, then scaled by pct/100 (pct = 100 -/+ tolerance).
  function automatic int unsigned win_cycles(input int unsigned us, input int unsigned clk_hz,
                                             input int unsigned pct);
    longint unsigned n;
    n = (64'(us) * 64'(clk_hz)) / 64'd1_000_000;
    return 32'((n * 64'(pct)) / 64'd100);
  endfunction

endpackage

// File: rtl/inf_rcv_nec_deglitch.sv
// Input conditioning for the NEC receiver: 2-flop synchroniser followed by a
// FILT_LEN-cycle persistence filter.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   inf_in             : raw demodulated IR input (idle high)
//   level              : filtered level
//   rise, fall         : one-cycle strobes, registered together with level
module inf_deglitch
  import inf_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic inf_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync2_q, level_q, rise_q, fall_q;
  logic [4:0] cnt_q;

  // Synchroniser and filter reset to the idle-high level so no edge appears at reset release.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= inf_in;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 5'(FILT_LEN - 1)) begin
        level_q <= sync2_q;
        rise_q  <= sync2_q;
        fall_q  <= ~sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 5'd1;
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/inf_rcv_nec.sv
// NEC infrared frame receiver.
// Measures filtered mark/space widths against tolerance windows, decodes the
// 32-bit frame LSB-first, validates it and tracks key-hold via repeat codes.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   inf_in             : demodulated IR input (idle high, mark low)
//   addr, cmd          : last valid address / command
//   data_vld           : pulse on a newly latched valid frame
//   repeat_vld         : pulse on an accepted repeat code
//   key_held           : high while the key is considered held
//   err                : pulse on framing, width, timeout or checksum error
// Build option: INF_EXT_ADDR_EN selects extended NEC (16-bit address, no
// address check); otherwise standard NEC with address/inverse check.
module inf_rcv_nec
  import inf_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ       = 50_000_000,
  parameter int unsigned TOL_PCT           = 25,
  parameter int unsigned FILT_LEN          = 4,
  parameter int unsigned REPEAT_TIMEOUT_MS = 120
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        inf_in,
  output logic [15:0] addr,
  output logic [7:0]  cmd,
  output logic        data_vld,
  output logic        repeat_vld,
  output logic        key_held,
  output logic        err
);

  localparam int unsigned PctLo   = 100 - TOL_PCT;
  localparam int unsigned PctHi   = 100 + TOL_PCT;
  localparam int unsigned LeadMax = win_cycles(LeadMarkUs, CLK_FREQ_HZ, PctHi);
  localparam int unsigned CntW    = $clog2(LeadMax) + 1;

  localparam logic [CntW-1:0] LeadLo = CntW'(win_cycles(LeadMarkUs, CLK_FREQ_HZ, PctLo));
  localparam logic [CntW-1:0] LeadHi = CntW'(LeadMax);
  localparam logic [CntW-1:0] DataLo = CntW'(win_cycles(DataSpaceUs, CLK_FREQ_HZ, PctLo));
  localparam logic [CntW-1:0] DataHi = CntW'(win_cycles(DataSpaceUs, CLK_FREQ_HZ, PctHi));
  localparam logic [CntW-1:0] RptLo  = CntW'(win_cycles(RptSpaceUs, CLK_FREQ_HZ, PctLo));
  localparam logic [CntW-1:0] RptHi  = CntW'(win_cycles(RptSpaceUs, CLK_FREQ_HZ, PctHi));
  localparam logic [CntW-1:0] BitLo  = CntW'(win_cycles(BitMarkUs, CLK_FREQ_HZ, PctLo));
  localparam logic [CntW-1:0] BitHi  = CntW'(win_cycles(BitMarkUs, CLK_FREQ_HZ, PctHi));
  localparam logic [CntW-1:0] ZeroLo = CntW'(win_cycles(ZeroSpaceUs, CLK_FREQ_HZ, PctLo));
  localparam logic [CntW-1:0] ZeroHi = CntW'(win_cycles(ZeroSpaceUs, CLK_FREQ_HZ, PctHi));
  localparam logic [CntW-1:0] OneLo  = CntW'(win_cycles(OneSpaceUs, CLK_FREQ_HZ, PctLo));
  localparam logic [CntW-1:0] OneHi  = CntW'(win_cycles(OneSpaceUs, CLK_FREQ_HZ, PctHi));
  localparam logic [CntW-1:0] CntMax = '1;

  localparam longint unsigned HoldCyc = (64'(REPEAT_TIMEOUT_MS) * 64'(CLK_FREQ_HZ)) / 64'd1000;
  localparam int unsigned     HoldW   = $clog2(HoldCyc + 1);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HoldCyc);

  function automatic logic in_win(input logic [CntW-1:0] c, input logic [CntW-1:0] lo,
                                  input logic [CntW-1:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

  logic             level, rise, fall, rise_ok, fall_ok;
  inf_state_e       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [4:0]       idx_q;
  logic [31:0]      shift_q;
  logic [15:0]      addr_q, frame_addr;
  logic [7:0]       cmd_q;
  logic             data_vld_q, repeat_vld_q, err_q, key_held_q;
  logic [HoldW-1:0] hold_q;
  logic             frame_ok, frame_end, rpt_end, hold_load, hold_clear;

  inf_deglitch #(
    .FILT_LEN (FILT_LEN)
  ) u_deglitch (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .inf_in    (inf_in),
    .level     (level),
    .rise      (rise),
    .fall      (fall)
  );

  // Strobes are only trusted when they agree with the filtered level.
  assign rise_ok = rise & level;
  assign fall_ok = fall & ~level;

  always_comb begin
    frame_ok   = 1'b0;
    frame_addr = 16'h0000;
`ifdef INF_EXT_ADDR_EN
    frame_ok   = (shift_q[23:16] == ~shift_q[31:24]);
    frame_addr = shift_q[15:0];
`else
    frame_ok   = (shift_q[23:16] == ~shift_q[31:24]) && (shift_q[7:0] == ~shift_q[15:8]);
    frame_addr = {8'h00, shift_q[7:0]};
`endif
  end

  assign frame_end  = (state_q == StStop) && rise_ok && in_win(cnt_q, BitLo, BitHi);
  assign rpt_end    = (state_q == StRptMark) && rise_ok && in_win(cnt_q, BitLo, BitHi);
  assign hold_load  = (frame_end && frame_ok) || (rpt_end && key_held_q);
  assign hold_clear = frame_end && !frame_ok;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      addr_q       <= '0;
      cmd_q        <= '0;
      data_vld_q   <= 1'b0;
      repeat_vld_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      data_vld_q   <= 1'b0;
      repeat_vld_q <= 1'b0;
      err_q        <= 1'b0;

      if (state_q == StIdle || rise_ok || fall_ok) begin
        cnt_q <= '0;
      end else if (cnt_q != CntMax) begin
        cnt_q <= cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (fall_ok) state_q <= StLead;
        end
        StLead: begin
          if (rise_ok) begin
            if (in_win(cnt_q, LeadLo, LeadHi)) begin
              state_q <= StSpace;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (cnt_q > LeadHi) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StSpace: begin
          if (fall_ok) begin
            if (in_win(cnt_q, DataLo, DataHi)) begin
              idx_q   <= '0;
              state_q <= StBitMark;
            end else if (in_win(cnt_q, RptLo, RptHi)) begin
              state_q <= StRptMark;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (cnt_q > DataHi) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StBitMark: begin
          if (rise_ok) begin
            if (in_win(cnt_q, BitLo, BitHi)) begin
              state_q <= StBitSpace;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (cnt_q > BitHi) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StBitSpace: begin
          if (fall_ok) begin
            if (in_win(cnt_q, ZeroLo, ZeroHi) || in_win(cnt_q, OneLo, OneHi)) begin
              // LSB-first: after 32 shifts bit 0 of byte0 sits in shift_q[0].
              shift_q <= {in_win(cnt_q, OneLo, OneHi), shift_q[31:1]};
              idx_q   <= idx_q + 5'd1;
              // The falling edge after the 32nd space starts the stop mark.
              state_q <= (idx_q == 5'd31) ? StStop : StBitMark;
            end else begin
              err_q   <= 1'b1;
              state_q <= StIdle;
            end
          end else if (cnt_q > OneHi) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StStop: begin
          if (rise_ok) begin
            state_q <= StIdle;
            if (frame_end && frame_ok) begin
              addr_q     <= frame_addr;
              cmd_q      <= shift_q[23:16];
              data_vld_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else if (cnt_q > BitHi) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        StRptMark: begin
          if (rise_ok) begin
            state_q <= StIdle;
            if (rpt_end) repeat_vld_q <= key_held_q;
            else         err_q        <= 1'b1;
          end else if (cnt_q > BitHi) begin
            err_q   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Hold timer; a reload in the same cycle as expiry keeps the key held.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_q     <= '0;
      key_held_q <= 1'b0;
    end else if (hold_load) begin
      hold_q     <= HoldLoad;
      key_held_q <= 1'b1;
    end else if (hold_clear) begin
      hold_q     <= '0;
      key_held_q <= 1'b0;
    end else if (hold_q != '0) begin
      hold_q <= hold_q - HoldW'(1);
      if (hold_q == HoldW'(1)) key_held_q <= 1'b0;
    end
  end

  assign addr       = addr_q;
  assign cmd        = cmd_q;
  assign data_vld   = data_vld_q;
  assign repeat_vld = repeat_vld_q;
  assign key_held   = key_held_q;
  assign err        = err_q;

endmodule

// File: tb/tb_inf_rcv_nec.sv
// Bench for inf_rcv_nec, run at a low clock rate so whole NEC frames fit in
// a short simulation. Expected results come from a frame-level model.
module tb_inf_rcv_nec;

  localparam int unsigned ClkHz  = 50_000;
  localparam int unsigned HoldMs = 120;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        inf_in = 1'b1;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        data_vld, repeat_vld, key_held, err;

  int total = 0;
  int bad = 0;
  int n_data = 0;
  int n_rpt = 0;
  int n_err = 0;
  int jit = 0;
  logic [15:0] exp_addr = 16'h0000;
  logic [7:0]  exp_cmd = 8'h00;

  inf_rcv_nec #(
    .CLK_FREQ_HZ       (ClkHz),
    .TOL_PCT           (25),
    .FILT_LEN          (4),
    .REPEAT_TIMEOUT_MS (HoldMs)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .inf_in     (inf_in),
    .addr       (addr),
    .cmd        (cmd),
    .data_vld   (data_vld),
    .repeat_vld (repeat_vld),
    .key_held   (key_held),
    .err        (err)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not finish within the time limit");
    $fatal(1);
  end

  // Pulse counters, plus an exclusivity check on every observed pulse.
  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      if (data_vld)   n_data++;
      if (repeat_vld) n_rpt++;
      if (err)        n_err++;
      if (data_vld || repeat_vld || err) begin
        total++;
        assert ($onehot0({data_vld, repeat_vld, err})) else begin
          bad++;
          $error("FAIL pulse_excl observed=%b expected=one-hot", {data_vld, repeat_vld, err});
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int cyc);
    inf_in = lvl;
    repeat (cyc) @(negedge sys_clk);
  endtask

  function automatic int cyc_of(input int unsigned us);
    longint n;
    int j;
    n = (longint'(us) * ClkHz) / 1_000_000;
    j = 0;
    if (jit > 0) j = int'($urandom_range(2 * jit, 0)) - jit;
    return int'((n * (100 + j)) / 100);
  endfunction

  function automatic logic model_ok(input logic [31:0] w);
    logic cmd_ok;
    cmd_ok = (w[23:16] == ~w[31:24]);
`ifdef INF_EXT_ADDR_EN
    return cmd_ok;
`else
    return cmd_ok && (w[7:0] == ~w[15:8]);
`endif
  endfunction

  function automatic logic [15:0] model_addr(input logic [31:0] w);
`ifdef INF_EXT_ADDR_EN
    return w[15:0];
`else
    return {8'h00, w[7:0]};
`endif
  endfunction

  // w = {byte3, byte2, byte1, byte0}; bits go out LSB-first from byte0.
  task automatic send_frame(input logic [31:0] w, input int nbits);
    hold(1'b0, cyc_of(9000));
    hold(1'b1, cyc_of(4500));
    for (int i = 0; i < nbits; i++) begin
      hold(1'b0, cyc_of(560));
      hold(1'b1, cyc_of(w[i] ? 1690 : 560));
    end
    if (nbits == 32) begin
      hold(1'b0, cyc_of(560));
      hold(1'b1, 40);
    end
  endtask

  task automatic send_repeat();
    hold(1'b0, cyc_of(9000));
    hold(1'b1, cyc_of(2250));
    hold(1'b0, cyc_of(560));
    hold(1'b1, 40);
  endtask

  task automatic do_frame(input string tag, input logic [31:0] w);
    int d0, e0;
    logic ok;
    d0 = n_data;
    e0 = n_err;
    ok = model_ok(w);
    send_frame(w, 32);
    if (ok) begin
      exp_addr = model_addr(w);
      exp_cmd  = w[23:16];
    end
    chk({tag, "_data_vld"}, n_data - d0, ok ? 1 : 0);
    chk({tag, "_err"}, n_err - e0, ok ? 0 : 1);
    chk({tag, "_addr"}, addr, exp_addr);
    chk({tag, "_cmd"}, cmd, exp_cmd);
    chk({tag, "_key_held"}, key_held, ok);
  endtask

  initial begin
    int r0, e0;
    logic [31:0] w;

    // Reset state
    repeat (5) @(negedge sys_clk);
    chk("rst_addr", addr, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_data_vld", data_vld, 0);
    chk("rst_repeat_vld", repeat_vld, 0);
    chk("rst_key_held", key_held, 0);
    chk("rst_err", err, 0);
    sys_rst_n = 1'b1;
    hold(1'b1, 20);

    // Standard frame 00 FF 45 BA
    do_frame("std", 32'hBA45_FF00);

    // Repeat while held, hold lifetime, then a repeat after expiry
    hold(1'b1, 1000);
    r0 = n_rpt;
    send_repeat();
    chk("rpt1_repeat_vld", n_rpt - r0, 1);
    chk("rpt1_key_held", key_held, 1);
    hold(1'b1, 5500);
    chk("hold_reloaded", key_held, 1);
    hold(1'b1, 700);
    chk("hold_expired", key_held, 0);
    r0 = n_rpt;
    e0 = n_err;
    send_repeat();
    chk("rpt2_repeat_vld", n_rpt - r0, 0);
    chk("rpt2_err", n_err - e0, 0);
    chk("rpt2_key_held", key_held, 0);

    // Good frame then one with a bad command inverse
    do_frame("good12", 32'hED12_FF00);
    do_frame("badinv", 32'hBB45_FF00);

    // 6 ms leader mark, then a 2-cycle glitch that must be filtered
    e0 = n_err;
    hold(1'b0, cyc_of(6000));
    hold(1'b1, 40);
    chk("short_lead_err", n_err - e0, 1);
    e0 = n_err;
    hold(1'b0, 2);
    hold(1'b1, 60);
    chk("glitch_err", n_err - e0, 0);
    do_frame("post_glitch", 32'h9F60_FE01);

    // Bytes 12 34 45 BA: valid only in extended-address builds
    do_frame("ext", 32'hBA45_3412);

    // Reset mid-frame at bit 17
    send_frame(32'hBA45_FF00, 17);
    hold(1'b0, 10);
    sys_rst_n = 1'b0;
    inf_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("midrst_addr", addr, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_key_held", key_held, 0);
    chk("midrst_pulses", {data_vld, repeat_vld, err}, 0);
    sys_rst_n = 1'b1;
    exp_addr = 16'h0000;
    exp_cmd  = 8'h00;
    hold(1'b1, 20);
    do_frame("after_rst", 32'hE718_FF00);

    // Randomized frames with timing jitter inside the tolerance
    jit = 8;
    for (int k = 0; k < 5; k++) begin
      w = $urandom;
      if ($urandom_range(3, 0) != 0) w[31:24] = ~w[23:16];
      if ($urandom_range(1, 0) != 0) w[15:8] = ~w[7:0];
      do_frame("rand", w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
